// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
//   fc_state_e     : sequencer states (encodings match the CPU-wide FC_* values)
//   InstrBytes     : PC increment per accepted instruction
//   DefaultResetPc : boot address used when the instantiation does not override it
//   is_aligned()   : true when an address is a legal 32-bit instruction address
package fetch_controller_pkg;

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StRun   = 2'd1,
        StHalt  = 2'd2,
        StFault = 2'd3
    } fc_state_e;

    localparam logic [31:0] InstrBytes     = 32'd4;
    localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

    function automatic logic is_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Bundle between the fetch sequencer and its neighbours (instruction_fetch and decode).
//   master : the sequencer side (drives load_en/pc_next and the decode-facing outputs)
//   slave  : the environment side (fetch stage, decode, branch unit, halt sources)
interface fetch_controller_if;

    logic [31:0] current_pc;
    logic [31:0] current_instr;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        resume;
    logic        load_en;
    logic [31:0] pc_next;
    logic        inst_valid;
    logic [31:0] inst_instr;
    logic [31:0] inst_pc;
    logic        halted;
    logic        fault;
    logic [31:0] fault_addr;
    logic [31:0] fetch_count;

    modport master (
        input  current_pc, current_instr, inst_ready, redirect_valid, redirect_target,
               halt_req, resume,
        output load_en, pc_next, inst_valid, inst_instr, inst_pc, halted, fault,
               fault_addr, fetch_count
    );

    modport slave (
        output current_pc, current_instr, inst_ready, redirect_valid, redirect_target,
               halt_req, resume,
        input  load_en, pc_next, inst_valid, inst_instr, inst_pc, halted, fault,
               fault_addr, fetch_count
    );

endinterface

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer. Boots the PC to RESET_PC after a short hold, advances it
// by 4 per instruction accepted by decode, applies branch/jump redirects, parks on halt
// requests and traps misaligned redirect targets in a sticky FAULT state.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : master side of fetch_controller_if
//                inputs  current_pc/current_instr (fetch stage), inst_ready (decode),
//                        redirect_valid/redirect_target, halt_req, resume
//                outputs load_en/pc_next (to fetch stage, combinational),
//                        inst_valid/inst_instr/inst_pc (to decode),
//                        halted, fault, fault_addr, fetch_count (status)
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [31:0] RESET_PC          = DefaultResetPc,
    parameter int unsigned RESET_HOLD_CYCLES = 2
) (
    input logic               clk,
    input logic               reset,
    fetch_controller_if.master bus
);

    // Counter only has to reach RESET_HOLD_CYCLES-1.
    localparam int unsigned      BootW    = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
    localparam logic [BootW-1:0] BootLast = BootW'(RESET_HOLD_CYCLES - 1);

    fc_state_e        state_q, state_d;
    logic [BootW-1:0] boot_cnt_q, boot_cnt_d;
    logic [31:0]      fault_addr_q, fault_addr_d;
    logic [31:0]      fetch_count_q, fetch_count_d;

    logic        load_en_raw;
    logic [31:0] pc_next_raw;
    logic        inst_valid_raw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StBoot;
            boot_cnt_q    <= '0;
            fault_addr_q  <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            boot_cnt_q    <= boot_cnt_d;
            fault_addr_q  <= fault_addr_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        boot_cnt_d     = boot_cnt_q;
        fault_addr_d   = fault_addr_q;
        fetch_count_d  = fetch_count_q;
        load_en_raw    = 1'b0;
        pc_next_raw    = RESET_PC;
        inst_valid_raw = 1'b0;

        unique case (state_q)
            StBoot: begin
                boot_cnt_d = boot_cnt_q + BootW'(1);
                if (boot_cnt_q == BootLast) begin
                    load_en_raw = 1'b1;
                    state_d     = StRun;
                end
            end
            StRun: begin
                if (bus.redirect_valid) begin
                    // Wrong-path instruction is squashed by leaving inst_valid low.
                    if (is_aligned(bus.redirect_target)) begin
                        load_en_raw = 1'b1;
                        pc_next_raw = bus.redirect_target;
                    end else begin
                        fault_addr_d = bus.redirect_target;
                        state_d      = StFault;
                    end
                end else if (bus.halt_req) begin
                    // PC is not advanced, so current_pc is re-presented after resume.
                    state_d = StHalt;
                end else begin
                    inst_valid_raw = 1'b1;
                    if (bus.inst_ready) begin
                        load_en_raw   = 1'b1;
                        pc_next_raw   = bus.current_pc + InstrBytes;
                        fetch_count_d = fetch_count_q + 32'd1;
                    end
                end
            end
            StHalt: begin
                if (bus.redirect_valid) begin
                    if (is_aligned(bus.redirect_target)) begin
                        load_en_raw = 1'b1;
                        pc_next_raw = bus.redirect_target;
                        state_d     = StRun;
                    end else begin
                        fault_addr_d = bus.redirect_target;
                        state_d      = StFault;
                    end
                end else if (bus.resume && !bus.halt_req) begin
                    state_d = StRun;
                end
            end
            StFault: begin
                // Sticky: only reset leaves this state.
            end
        endcase
    end

    // Reset forces the fetch-facing outputs idle at once, abandoning any in-flight load.
    assign bus.load_en     = load_en_raw & ~reset;
    assign bus.pc_next     = (load_en_raw && !reset) ? pc_next_raw : RESET_PC;
    assign bus.inst_valid  = inst_valid_raw & ~reset;
    assign bus.inst_instr  = bus.current_instr;
    assign bus.inst_pc     = bus.current_pc;
    assign bus.halted      = (state_q == StHalt) & ~reset;
    assign bus.fault       = (state_q == StFault) & ~reset;
    assign bus.fault_addr  = fault_addr_q;
    assign bus.fetch_count = fetch_count_q;

endmodule
